// File: rtl/c_pkg.sv
// Shared types and sizing helpers for the multi-cycle unary-code sequencer.
package c_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int f_beats(input int w, input int c);
        return w / c;
    endfunction

    // Counter width that stays >= 1 even when only one value is needed.
    function automatic int f_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int f_val_w(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/c_cell.sv
// One bit of the unary checker: tracks the run-to-tail edge and kills admit on a second edge.
module c_cell #(
    parameter int P_IS_FIRST      = 0,
    parameter int P_IS_COMPLIMENT = 0
) (
    input  logic i_x,
    input  logic i_x_prev,
    input  logic i_admit,
    input  logic i_edge_seen,
    output logic o_admit,
    output logic o_edge_seen
);

    localparam logic RUN_V = 1'(P_IS_COMPLIMENT == 0);

    logic is_edge;

    assign is_edge = (i_x_prev == RUN_V) && (i_x != RUN_V);

    generate
        if (P_IS_FIRST != 0) begin : g_first
            assign o_admit     = (i_x == RUN_V);
            assign o_edge_seen = 1'b0;
        end else begin : g_mid
            // Any return to the run value forces either a second edge or a bad MSB,
            // so rejecting the second edge is enough.
            assign o_admit     = i_admit & ~(is_edge & i_edge_seen);
            assign o_edge_seen = i_edge_seen | is_edge;
        end
    endgenerate

endmodule

// File: rtl/c_unary_lanes.sv
// Combinational P_C-lane chain of c_cell; reports the lane where the first edge appears.
module c_unary_lanes
    import c_pkg::*;
#(
    parameter int P_C             = 8,
    parameter int P_IS_COMPLIMENT = 0,
    localparam int LW             = f_cnt_w(P_C)
) (
    input  logic [P_C-1:0] i_chunk,
    input  logic           i_x_prev,
    input  logic           i_admit,
    input  logic           i_edge_seen,
    output logic           o_x_prev,
    output logic           o_admit,
    output logic           o_edge_seen,
    output logic           o_hit,
    output logic [LW-1:0]  o_hit_lane
);

    logic [P_C:0] admit_c;
    logic [P_C:0] edge_c;
    logic [P_C:0] prev_c;

    assign admit_c[0] = i_admit;
    assign edge_c[0]  = i_edge_seen;
    assign prev_c[0]  = i_x_prev;

    genvar j;
    generate
        for (j = 0; j < P_C; j++) begin : g_lane
            assign prev_c[j+1] = i_chunk[j];
            c_cell #(
                .P_IS_FIRST     (0),
                .P_IS_COMPLIMENT(P_IS_COMPLIMENT)
            ) u_cell (
                .i_x        (i_chunk[j]),
                .i_x_prev   (prev_c[j]),
                .i_admit    (admit_c[j]),
                .i_edge_seen(edge_c[j]),
                .o_admit    (admit_c[j+1]),
                .o_edge_seen(edge_c[j+1])
            );
        end
    endgenerate

    assign o_x_prev    = prev_c[P_C];
    assign o_admit     = admit_c[P_C];
    assign o_edge_seen = edge_c[P_C];
    assign o_hit       = edge_c[P_C] & ~edge_c[0];

    // edge_seen is monotonic along the chain, so at most one lane rises.
    always_comb begin
        o_hit_lane = '0;
        for (int k = 0; k < P_C; k++) begin
            if (edge_c[k+1] && !edge_c[k]) o_hit_lane = LW'(k);
        end
    end

endmodule

// File: rtl/c_unary_seq.sv
// Multi-cycle unary (thermometer) code checker/decoder, P_C bits per beat with valid/ready on both sides.
module c_unary_seq
    import c_pkg::*;
#(
    parameter int P_W             = 32,
    parameter int P_C             = 8,
    parameter int P_IS_COMPLIMENT = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_in_vld,
    input  logic [P_W-1:0]         i_in_x,
    output logic                   o_in_rdy,
    output logic                   o_out_vld,
    input  logic                   i_out_rdy,
    output logic                   o_out_is_unary,
    output logic [$clog2(P_W)-1:0] o_out_value,
    output logic                   o_busy
);

    localparam int   N      = f_beats(P_W, P_C);
    localparam int   CW     = f_cnt_w(N);
    localparam int   VW     = f_val_w(P_W);
    localparam int   LW     = f_cnt_w(P_C);
    localparam logic COMP_V = 1'(P_IS_COMPLIMENT != 0);

    generate
        if (P_C < 1 || P_W < 2 || (P_W % P_C) != 0) begin : g_bad_params
            $error("c_unary_seq: P_W must be >= 2 and a multiple of P_C >= 1");
        end
    endgenerate

    state_t          state, state_nxt;
    logic [P_W-1:0]  vec;
    logic [CW-1:0]   beat;
    logic            c_prev, c_admit, c_edge;
    logic            found;
    logic [VW-1:0]   edge_val;
    logic            res_unary;
    logic [VW-1:0]   res_value;

    logic [P_C-1:0]  chunk;
    logic            n_prev, n_admit, n_edge, hit;
    logic [LW-1:0]   hit_lane;
    logic [VW-1:0]   hit_val;
    logic            last_beat, accept, verdict;

    assign chunk     = vec[int'(beat)*P_C +: P_C];
    assign last_beat = (beat == CW'(N - 1));
    assign accept    = i_in_vld & o_in_rdy;
    assign hit_val   = VW'(int'(beat) * P_C + int'(hit_lane));
    assign verdict   = n_edge & n_admit & (chunk[P_C-1] == COMP_V);

    c_unary_lanes #(
        .P_C            (P_C),
        .P_IS_COMPLIMENT(P_IS_COMPLIMENT)
    ) u_lanes (
        .i_chunk    (chunk),
        .i_x_prev   (c_prev),
        .i_admit    (c_admit),
        .i_edge_seen(c_edge),
        .o_x_prev   (n_prev),
        .o_admit    (n_admit),
        .o_edge_seen(n_edge),
        .o_hit      (hit),
        .o_hit_lane (hit_lane)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_in_vld) state_nxt = RUN;
            RUN:  if (last_beat) state_nxt = DONE;
            DONE: if (i_out_rdy) state_nxt = i_in_vld ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_in_rdy  = 1'b0;
        o_out_vld = 1'b0;
        o_busy    = (state != IDLE);
        case (state)
            IDLE: o_in_rdy = 1'b1;
            DONE: begin
                o_out_vld = 1'b1;
                o_in_rdy  = i_out_rdy;
            end
            default: ;
        endcase
    end

    // Seeding from x[0] means bit 0 can never register as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec       <= '0;
            beat      <= '0;
            c_prev    <= 1'b0;
            c_admit   <= 1'b0;
            c_edge    <= 1'b0;
            found     <= 1'b0;
            edge_val  <= '0;
            res_unary <= 1'b0;
            res_value <= '0;
        end else if (accept) begin
            vec      <= i_in_x;
            beat     <= '0;
            c_prev   <= i_in_x[0];
            c_admit  <= (i_in_x[0] == ~COMP_V);
            c_edge   <= 1'b0;
            found    <= 1'b0;
            edge_val <= '0;
        end else if (state == RUN) begin
            beat    <= beat + 1'b1;
            c_prev  <= n_prev;
            c_admit <= n_admit;
            c_edge  <= n_edge;
            if (hit && !found) begin
                found    <= 1'b1;
                edge_val <= hit_val;
            end
            if (last_beat) begin
                res_unary <= verdict;
                res_value <= verdict ? (found ? edge_val : hit_val) : '0;
            end
        end
    end

    assign o_out_is_unary = res_unary;
    assign o_out_value    = res_value;

endmodule
